// File: rtl/vm2413_pkg.sv
// Shared VM2413 voice-memory types, user-patch IDs and the user-patch register field map.
package vm2413_pkg;

  typedef struct packed {
    logic       am;
    logic       pm;
    logic       eg;
    logic       kr;
    logic [3:0] ml;
    logic [1:0] kl;
    logic [5:0] tl;
    logic       wf;
    logic [2:0] fb;
    logic [3:0] ar;
    logic [3:0] dr;
    logic [3:0] sl;
    logic [3:0] rr;
  } VOICE_TYPE;

  typedef logic [5:0] VOICE_ID_TYPE;

  localparam VOICE_ID_TYPE USER_MOD_ID   = 6'd0;
  localparam VOICE_ID_TYPE USER_CAR_ID   = 6'd1;
  localparam int           PATCH_ENTRY_W = 11;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_RD,
    ST_WT,
    ST_WR,
    ST_NEXT
  } vp_state_t;

  // $03 starts on the modulator; its carrier pass is selected later via car_pass.
  function automatic VOICE_ID_TYPE patch_target(input logic [2:0] addr);
    return (addr == 3'd1 || addr == 3'd5 || addr == 3'd7) ? USER_CAR_ID : USER_MOD_ID;
  endfunction

  function automatic VOICE_TYPE patch_merge(input VOICE_TYPE v, input logic [2:0] addr,
                                            input logic [7:0] d, input logic car_pass);
    VOICE_TYPE r;
    r = v;
    case (addr)
      3'd0, 3'd1: {r.am, r.pm, r.eg, r.kr, r.ml} = d;
      3'd2:       {r.kl, r.tl} = d;
      3'd3: begin
        if (car_pass) begin
          r.kl = d[7:6];
          r.wf = d[4];
        end else begin
          {r.wf, r.fb} = d[3:0];
        end
      end
      3'd4, 3'd5: {r.ar, r.dr} = d;
      default:    {r.sl, r.rr} = d;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/patch_wr_fifo.sv
// Register-write queue: {addr[2:0], data[7:0]} entries, head visible combinationally.
module patch_wr_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 11
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         empty,
  output logic         full
);

  localparam int            AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]   FULL_CNT = DEPTH[AW:0];

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop && !empty;
  // A pop frees the slot the same cycle, so a push into a full queue can still land.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/voice_patch_ctrl.sv
// Applies queued CPU user-patch register writes to voice memory by read-modify-write.
module voice_patch_ctrl
  import vm2413_pkg::*;
#(
  parameter int INIT_CYCLES = 116,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         reg_wr,
  input  logic [2:0]   reg_addr,
  input  logic [7:0]   reg_data,
  output logic         reg_ready,
  output VOICE_ID_TYPE vm_rwaddr,
  input  VOICE_TYPE    vm_odata,
  output VOICE_TYPE    vm_idata,
  output logic         vm_wr,
  output logic         busy,
  output logic         overflow,
  output vp_state_t    dbg_state
);

  localparam int CW = $clog2(INIT_CYCLES + 1);

  // reg_wr/reg_ready: a write is taken on a rising edge where both are high;
  // reg_wr with reg_ready low is dropped and latches overflow.
  vp_state_t                state;
  logic [CW-1:0]            init_cnt;
  logic [2:0]               cur_addr;
  logic [7:0]               cur_data;
  logic                     car_pass;
  logic [PATCH_ENTRY_W-1:0] fifo_head;
  logic                     fifo_empty;
  logic                     fifo_full;
  logic                     fifo_pop;

  assign reg_ready = !fifo_full;
  assign fifo_pop  = (state == ST_IDLE) && !fifo_empty;
  assign busy      = (state != ST_IDLE) || !fifo_empty;
  assign dbg_state = state;

  patch_wr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (PATCH_ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (reg_wr && reg_ready),
    .push_data ({reg_addr, reg_data}),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= ST_INIT;
      init_cnt  <= '0;
      vm_wr     <= 1'b0;
      vm_rwaddr <= '0;
      vm_idata  <= '0;
      overflow  <= 1'b0;
      cur_addr  <= '0;
      cur_data  <= '0;
      car_pass  <= 1'b0;
    end else begin
      vm_wr <= 1'b0;
      if (reg_wr && !reg_ready) overflow <= 1'b1;
      case (state)
        ST_INIT: begin
          if (init_cnt == CW'(INIT_CYCLES - 1)) state <= ST_IDLE;
          else                                  init_cnt <= init_cnt + 1'b1;
        end
        ST_IDLE: begin
          if (!fifo_empty) begin
            cur_addr  <= fifo_head[10:8];
            cur_data  <= fifo_head[7:0];
            car_pass  <= 1'b0;
            vm_rwaddr <= patch_target(fifo_head[10:8]);
            state     <= ST_RD;
          end
        end
        ST_RD: state <= ST_WT;
        // Read data arrives here and is merged straight into the write word.
        ST_WT: begin
          vm_idata <= patch_merge(vm_odata, cur_addr, cur_data, car_pass);
          vm_wr    <= 1'b1;
          state    <= ST_WR;
        end
        ST_WR: state <= (cur_addr == 3'd3 && !car_pass) ? ST_NEXT : ST_IDLE;
        ST_NEXT: begin
          car_pass  <= 1'b1;
          vm_rwaddr <= USER_CAR_ID;
          state     <= ST_RD;
        end
        default: state <= ST_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_voice_patch_ctrl.sv
// Directed bench for voice_patch_ctrl with a registered-read voice memory model.
module tb_voice_patch_ctrl;
  import vm2413_pkg::*;

  localparam int          INIT_CYCLES = 116;
  localparam int          W           = 42;
  localparam logic [35:0] M0          = 36'h13579BDF0;
  localparam logic [35:0] C1          = 36'h24682CE02;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         reg_wr;
  logic [2:0]   reg_addr;
  logic [7:0]   reg_data;
  logic         reg_ready;
  VOICE_ID_TYPE vm_rwaddr;
  VOICE_TYPE    vm_odata;
  VOICE_TYPE    vm_idata;
  logic         vm_wr;
  logic         busy;
  logic         overflow;
  vp_state_t    dbg_state;

  always #5 clk = ~clk;

  voice_patch_ctrl #(.INIT_CYCLES(INIT_CYCLES), .FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .reg_wr    (reg_wr),
    .reg_addr  (reg_addr),
    .reg_data  (reg_data),
    .reg_ready (reg_ready),
    .vm_rwaddr (vm_rwaddr),
    .vm_odata  (vm_odata),
    .vm_idata  (vm_idata),
    .vm_wr     (vm_wr),
    .busy      (busy),
    .overflow  (overflow),
    .dbg_state (dbg_state)
  );

  // Voice memory model: one-cycle read latency, mem_load restores the two user entries.
  VOICE_TYPE mem [64];
  logic      mem_load;
  always @(posedge clk) begin
    if (mem_load) begin
      mem[0] <= M0;
      mem[1] <= C1;
    end else if (vm_wr === 1'b1) begin
      mem[vm_rwaddr] <= vm_idata;
    end
    vm_odata <= mem[vm_rwaddr];
  end

  int cyc;
  always @(posedge clk) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_exp;
  int total = 0;
  int bad = 0;
  int wr_count = 0;
  int last_wr_cyc = 0;
  int push_cyc = 0;
  int wr0 = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (vm_wr === 1'b1) begin
      wr_count++;
      last_wr_cyc = cyc;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_wr: got id=%0h word=%0h expected no write", vm_rwaddr, vm_idata);
      end else begin
        mon_exp = exp_q.pop_front();
        check("vm_write", {vm_rwaddr, vm_idata}, mon_exp);
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    reg_wr  = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic push(input logic [2:0] a, input logic [7:0] d);
    reg_wr   = 1'b1;
    reg_addr = a;
    reg_data = d;
    @(negedge clk);
    reg_wr   = 1'b0;
    push_cyc = cyc;
  endtask

  task automatic load_mem();
    mem_load = 1'b1;
    @(negedge clk);
    mem_load = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    @(negedge clk);
    while (busy !== 1'b0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check(name, busy, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_vm_wr"},     vm_wr, 1'b0);
    check({tag, "_vm_rwaddr"}, vm_rwaddr, 6'd0);
    check({tag, "_vm_idata"},  vm_idata, 36'd0);
    check({tag, "_overflow"},  overflow, 1'b0);
    check({tag, "_busy"},      busy, 1'b1);
    check({tag, "_reg_ready"}, reg_ready, 1'b1);
    check({tag, "_state"},     dbg_state, ST_INIT);
  endtask

  typedef struct {
    logic [2:0]  addr;
    logic [7:0]  data;
    int          n_wr;
    logic [5:0]  id0;
    logic [35:0] w0;
    logic [5:0]  id1;
    logic [35:0] w1;
  } vec_t;

  vec_t vecs[9];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{3'd0, 8'h61, 1, 6'd0, 36'h61579BDF0, 6'd0, 36'd0};
    vecs[1] = '{3'd1, 8'h21, 1, 6'd1, 36'h21682CE02, 6'd0, 36'd0};
    vecs[2] = '{3'd2, 8'hC7, 1, 6'd0, 36'h13C79BDF0, 6'd0, 36'd0};
    vecs[3] = '{3'd4, 8'hF2, 1, 6'd0, 36'h13579F2F0, 6'd0, 36'd0};
    vecs[4] = '{3'd5, 8'h3B, 1, 6'd1, 36'h246823B02, 6'd0, 36'd0};
    vecs[5] = '{3'd6, 8'h5A, 1, 6'd0, 36'h13579BD5A, 6'd0, 36'd0};
    vecs[6] = '{3'd7, 8'h0E, 1, 6'd1, 36'h24682CE0E, 6'd0, 36'd0};
    vecs[7] = '{3'd3, 8'hD5, 2, 6'd0, 36'h13575BDF0, 6'd1, 36'h24E8ACE02};
    vecs[8] = '{3'd3, 8'h28, 2, 6'd0, 36'h13578BDF0, 6'd1, 36'h24282CE02};

    reset_n  = 1'b0;
    reg_wr   = 1'b0;
    reg_addr = 3'd0;
    reg_data = 8'd0;
    mem_load = 1'b1;
    do_reset();
    mem_load = 1'b0;
    check_reset_outputs("rst0");

    // Write queued during init waits for the init window to close.
    while (cyc < 4) @(negedge clk);
    exp_q.push_back({USER_MOD_ID, 36'h13579F2F0});
    wr0 = wr_count;
    push(3'd4, 8'hF2);
    while (cyc < INIT_CYCLES - 1) @(negedge clk);
    check("init_last_state", dbg_state, ST_INIT);
    check("init_no_wr", wr_count - wr0, 0);
    @(negedge clk);
    check("init_exit_state", dbg_state, ST_IDLE);
    wait_idle("init_wr_idle");
    check("init_wr_count", wr_count - wr0, 1);
    check("init_wr_cycle", last_wr_cyc, INIT_CYCLES + 3);

    for (int i = 0; i < 9; i++) begin
      load_mem();
      exp_q.push_back({vecs[i].id0, vecs[i].w0});
      if (vecs[i].n_wr == 2) exp_q.push_back({vecs[i].id1, vecs[i].w1});
      wr0 = wr_count;
      push(vecs[i].addr, vecs[i].data);
      wait_idle($sformatf("vec%0d_idle", i));
      check($sformatf("vec%0d_count", i), wr_count - wr0, vecs[i].n_wr);
      check($sformatf("vec%0d_latency", i), last_wr_cyc - push_cyc, 4 * vecs[i].n_wr - 1);
    end

    // Back-to-back pushes are serviced in order.
    load_mem();
    exp_q.push_back({USER_MOD_ID, 36'h61579BDF0});
    exp_q.push_back({USER_CAR_ID, 36'h21682CE02});
    wr0 = wr_count;
    push(3'd0, 8'h61);
    push(3'd1, 8'h21);
    wait_idle("b2b_idle");
    check("b2b_count", wr_count - wr0, 2);
    check("b2b_last_cycle", last_wr_cyc - push_cyc, 6);

    // Five pushes during init: fifth is dropped, the rest merge in sequence.
    mem_load = 1'b1;
    do_reset();
    mem_load = 1'b0;
    exp_q.push_back({USER_MOD_ID, 36'h13579BD5A});
    exp_q.push_back({USER_CAR_ID, 36'h24682CE0E});
    exp_q.push_back({USER_MOD_ID, 36'h13C79BD5A});
    exp_q.push_back({USER_CAR_ID, 36'h246823B0E});
    wr0 = wr_count;
    push(3'd6, 8'h5A);
    push(3'd7, 8'h0E);
    push(3'd2, 8'hC7);
    check("ovf_ready_at3", reg_ready, 1'b1);
    push(3'd5, 8'h3B);
    check("ovf_ready_full", reg_ready, 1'b0);
    check("ovf_before_drop", overflow, 1'b0);
    push(3'd4, 8'hF2);
    check("ovf_set", overflow, 1'b1);
    check("ovf_ready_still_full", reg_ready, 1'b0);
    wait_idle("ovf_idle");
    check("ovf_wr_count", wr_count - wr0, 4);
    check("ovf_sticky", overflow, 1'b1);

    // Reset during WT abandons the write and restarts init.
    load_mem();
    wr0 = wr_count;
    push(3'd6, 8'h5A);
    repeat (2) @(negedge clk);
    check("abort_in_wt", dbg_state, ST_WT);
    reset_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("abort");
    reset_n = 1'b1;
    while (cyc < INIT_CYCLES - 1) @(negedge clk);
    check("abort_init_state", dbg_state, ST_INIT);
    @(negedge clk);
    check("abort_idle_state", dbg_state, ST_IDLE);
    check("abort_busy", busy, 1'b0);
    check("abort_no_wr", wr_count - wr0, 0);
    check("exp_q_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/voice_patch_ctrl.md
VOICE_PATCH_CTRL -- requirements
Module: voice_patch_ctrl

Interface
REQ-001 SHALL have parameter INIT_CYCLES, default 116: cycles after reset before voice memory is accessed (38 entries x 3 cycles, plus 2).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: register-write queue depth, power of two.
REQ-003 clk  in  1  single clock, all logic on rising edge.
REQ-004 reset_n  in  1  synchronous, active-low reset.
REQ-005 reg_wr  in  1  CPU write strobe for user-patch registers $00-$07.
REQ-006 reg_addr  in  3  user-patch register index.
REQ-007 reg_data  in  8  user-patch register value.
REQ-008 reg_ready  out  1  queue not full; reg_wr is accepted only when high.
REQ-009 vm_rwaddr  out  VOICE_ID_TYPE  read/write address to voice memory.
REQ-010 vm_odata  in  VOICE_TYPE  voice memory read data, valid 1 cycle after vm_rwaddr.
REQ-011 vm_idata  out  VOICE_TYPE  merged write data.
REQ-012 vm_wr  out  1  one-cycle write strobe.
REQ-013 busy  out  1  init wait active, queue non-empty, or FSM not IDLE.
REQ-014 overflow  out  1  sticky; set by reg_wr while reg_ready is low.

Function
REQ-015 Accepted writes SHALL enter a FIFO and be serviced strictly in order, one at a time.
REQ-016 FSM states SHALL be INIT, IDLE, RD, WT, WR, NEXT.
REQ-017 INIT: count INIT_CYCLES, then go to IDLE; vm_wr=0 throughout; FIFO accepts writes.
REQ-018 IDLE: when FIFO non-empty, pop head, drive vm_rwaddr = target ID, go to RD.
REQ-019 RD->WT unconditionally; in WT capture vm_odata (read latency 1); WT->WR.
REQ-020 WR: assert vm_wr for exactly one cycle with vm_idata = captured word with register fields replaced; vm_rwaddr held.
REQ-021 Target IDs: user modulator = 0, user carrier = 1.
REQ-022 Field map: $00/$01 -> mod/car {AM,PM,EG,KR,ML} = data[7],[6],[5],[4],[3:0]; $02 -> mod {KL=data[7:6], TL=data[5:0]}; $04/$05 -> mod/car {AR=data[7:4], DR=data[3:0]}; $06/$07 -> mod/car {SL=data[7:4], RR=data[3:0]}.
REQ-023 $03 SHALL take two read-modify-write passes: mod {WF=data[3], FB=data[2:0]}, then car {KL=data[7:6], WF=data[4]}; NEXT starts the car pass at RD, else returns to IDLE.
REQ-024 Fields not named for the register SHALL be preserved bit-exactly.
REQ-025 A single write SHALL complete in 4 cycles from pop (IDLE, RD, WT, WR); $03 in 8.
REQ-026 Simultaneous push and pop SHALL be allowed when full; reg_ready = !full, combinational from FIFO count.
REQ-027 FIFO pointers SHALL wrap modulo FIFO_DEPTH; count width log2(FIFO_DEPTH)+1.
REQ-028 A reg_wr while full SHALL be dropped and set overflow; overflow clears only on reset.
REQ-029 vm_wr SHALL never assert in INIT or at any cycle other than WR.

Reset
REQ-030 On reset_n=0 at a clock edge: state=INIT, init counter=0, FIFO empty, vm_wr=0, vm_rwaddr=0, vm_idata=0, overflow=0, busy=1.
REQ-031 Reset mid-RMW SHALL abandon the operation with no write issued; queued writes are lost.

Structure
REQ-032 VOICE_TYPE, VOICE_ID_TYPE, user voice IDs 0/1 and register field map SHALL be defined in the shared vm2413 package.
REQ-033 The FIFO SHALL be a sub-module named patch_wr_fifo (parameterised depth, 11-bit entries).

Verification
REQ-034 Reset, reg_wr $04=0xF2 at cycle 5 -> no vm_wr before cycle INIT_CYCLES; then one vm_wr at ID 0 with AR=F, DR=2, other fields unchanged.
REQ-035 After init, $03=0xD5 -> two vm_wr: ID 0 WF=0, FB=5; then ID 1 KL=3, WF=1; 8 cycles total.
REQ-036 Back-to-back $00=0x61, $01=0x21 -> ID 0 ML=1 AM=0 PM=1 EG=1 KR=0, then ID 1 ML=1 EG=1; in order.
REQ-037 Push 5 writes in 5 cycles during INIT (depth 4) -> reg_ready low after 4th, 5th dropped, overflow=1, exactly 4 writes executed.
REQ-038 Assert reset_n=0 in WT of a $06 write -> no vm_wr; outputs at reset values next cycle; INIT restarts.
